// File: rtl/ot_receiver_rsa_pkg.sv
// Shared definitions for the receiver-side RSA oblivious-transfer engine:
// controller state encoding and default datapath geometry.
package ot_pkg;

   localparam int STATE_W     = 3;
   localparam int DEF_WIDTH   = 32;
   localparam int DEF_NUM_MSG = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE = 3'd0,
      EXP  = 3'd1,
      RED  = 3'd2,
      ADD  = 3'd3,
      OUT  = 3'd4
   } ot_state_e;

endpackage

// File: rtl/ot_receiver_rsa_if.sv
// Request/result bus of ot_receiver_rsa. The master (protocol controller)
// drives the request side and accepts the result; the slave is the engine.
interface ot_receiver_rsa_if #(
   parameter int WIDTH   = ot_pkg::DEF_WIDTH,
   parameter int NUM_MSG = ot_pkg::DEF_NUM_MSG
);
   localparam int SEL_W = $clog2(NUM_MSG);

   logic                     start;
   logic                     in_ready;
   logic [SEL_W-1:0]         sel;
   logic [NUM_MSG*WIDTH-1:0] rand_msgs;
   logic [WIDTH-1:0]         N;
   logic [WIDTH-1:0]         pub_key;
   logic [WIDTH-1:0]         rand_val;
   logic                     out_valid;
   logic                     out_ready;
   logic [WIDTH-1:0]         v;
   logic                     err;

   modport master (
      output start, sel, rand_msgs, N, pub_key, rand_val, out_ready,
      input  in_ready, out_valid, v, err
   );

   modport slave (
      input  start, sel, rand_msgs, N, pub_key, rand_val, out_ready,
      output in_ready, out_valid, v, err
   );
endinterface

// File: rtl/ot_receiver_rsa_modexp.sv
// rl_modexp: right-to-left binary modular exponentiation r = base^exp mod modulus.
// The base is first reduced bit-serially (WIDTH cycles), then each exponent bit
// costs WIDTH cycles of interleaved shift-add modular multiplication, with the
// conditional multiply and the squaring running side by side over the same
// base bits. Iteration stops once no set exponent bits remain, so latency is
// WIDTH * (1 + index of highest set bit of exp + 1). modulus must be >= 2.
// md_end is a one-cycle pulse; r holds until the next run completes.
module rl_modexp
   import ot_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             md_start,
   input  logic [WIDTH-1:0] base,
   input  logic [WIDTH-1:0] exp,
   input  logic [WIDTH-1:0] modulus,
   output logic [WIDTH-1:0] r,
   output logic             md_end
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   typedef enum logic [1:0] {E_IDLE, E_RED, E_MUL} eng_state_e;

   eng_state_e       st_q, st_d;
   logic [WIDTH-1:0] mod_q, mod_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [WIDTH-1:0] base_q, base_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] sh_q, sh_d;
   logic [WIDTH-1:0] pa_q, pa_d;
   logic [WIDTH-1:0] ps_q, ps_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] r_q, r_d;
   logic             end_q, end_d;
   logic [WIDTH-1:0] pa_step, ps_step, acc_nx;

   // One interleaved step: p <- (2p + bit*b) mod m, valid for p < m, b < m.
   function automatic logic [WIDTH-1:0] mm_step(input logic [WIDTH-1:0] p,
                                                input logic             bit_i,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] m);
      logic [WIDTH+1:0] t;
      t = {1'b0, p, 1'b0} + (bit_i ? {2'b00, b} : '0);
      if (t >= {2'b00, m}) t = t - {2'b00, m};
      if (t >= {2'b00, m}) t = t - {2'b00, m};
      return WIDTH'(t);
   endfunction

   // Sequencing of reduction and per-bit multiply/square passes.
   always_comb begin
      st_d    = st_q;
      mod_d   = mod_q;
      exp_d   = exp_q;
      base_d  = base_q;
      acc_d   = acc_q;
      sh_d    = sh_q;
      pa_d    = pa_q;
      ps_d    = ps_q;
      cnt_d   = cnt_q;
      r_d     = r_q;
      end_d   = 1'b0;
      acc_nx  = acc_q;
      // During reduction the multiplicand is 1, turning the step into base mod m.
      pa_step = mm_step(pa_q, sh_q[WIDTH-1], (st_q == E_RED) ? ONE : acc_q, mod_q);
      ps_step = mm_step(ps_q, sh_q[WIDTH-1], base_q, mod_q);
      case (st_q)
         E_IDLE: begin
            if (md_start) begin
               mod_d = modulus;
               exp_d = exp;
               sh_d  = base;
               pa_d  = '0;
               cnt_d = CNT_MAX;
               st_d  = E_RED;
            end
         end
         E_RED: begin
            pa_d  = pa_step;
            sh_d  = sh_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               base_d = pa_step;
               acc_d  = ONE;
               sh_d   = pa_step;
               pa_d   = '0;
               ps_d   = '0;
               cnt_d  = CNT_MAX;
               if (exp_q == '0) begin
                  r_d   = ONE;
                  end_d = 1'b1;
                  st_d  = E_IDLE;
               end else begin
                  st_d  = E_MUL;
               end
            end
         end
         E_MUL: begin
            pa_d  = pa_step;
            ps_d  = ps_step;
            sh_d  = sh_q << 1;
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) begin
               acc_nx = exp_q[0] ? pa_step : acc_q;
               exp_d  = exp_q >> 1;
               if (exp_q[WIDTH-1:1] == '0) begin
                  r_d   = acc_nx;
                  end_d = 1'b1;
                  st_d  = E_IDLE;
               end else begin
                  acc_d  = acc_nx;
                  base_d = ps_step;
                  sh_d   = ps_step;
                  pa_d   = '0;
                  ps_d   = '0;
                  cnt_d  = CNT_MAX;
               end
            end
         end
         default: st_d = E_IDLE;
      endcase
   end

   // Engine registers; reset abandons any run in progress.
   always_ff @(posedge clk) begin
      if (rst) begin
         st_q   <= E_IDLE;
         mod_q  <= '0;
         exp_q  <= '0;
         base_q <= '0;
         acc_q  <= '0;
         sh_q   <= '0;
         pa_q   <= '0;
         ps_q   <= '0;
         cnt_q  <= '0;
         r_q    <= '0;
         end_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         mod_q  <= mod_d;
         exp_q  <= exp_d;
         base_q <= base_d;
         acc_q  <= acc_d;
         sh_q   <= sh_d;
         pa_q   <= pa_d;
         ps_q   <= ps_d;
         cnt_q  <= cnt_d;
         r_q    <= r_d;
         end_q  <= end_d;
      end
   end

   assign r      = r_q;
   assign md_end = end_q;

endmodule

// File: rtl/ot_receiver_rsa.sv
// ot_receiver_rsa: receiver side of 1-of-NUM_MSG RSA oblivious transfer.
// Computes v = (k^e mod N + x_sel mod N) mod N using one shared rl_modexp
// (second pass with exp=1 reduces x_sel), then holds v on a valid/ready port.
// Optional build macro OT_RECEIVER_RANGE_CHECK_EN additionally rejects
// rand_val >= N or x_sel >= N at request time.
//
// state | meaning
// IDLE  | ready for a request; operands captured on start
// EXP   | engine computing k^e mod N
// RED   | engine computing x_sel mod N
// ADD   | modular addition of the two partial results
// OUT   | result (or error) presented until out_ready
module ot_receiver_rsa
   import ot_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int NUM_MSG = DEF_NUM_MSG
) (
   input  logic              clk,
   input  logic              rst,
   ot_receiver_rsa_if.slave  bus
);

   localparam int SEL_W = $clog2(NUM_MSG);

   ot_state_e        state_q, state_d;
   logic [WIDTH-1:0] n_q, n_d;
   logic [WIDTH-1:0] e_q, e_d;
   logic [WIDTH-1:0] k_q, k_d;
   logic [WIDTH-1:0] x_q, x_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] v_q, v_d;
   logic             err_q, err_d;
   logic             md_start_q, md_start_d;

   logic [WIDTH-1:0] x_sel;
   logic             req_err;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] eng_base, eng_exp, eng_r;
   logic             eng_end;

   // Selection mux and request validity; unused indices select zero.
   always_comb begin
      x_sel = '0;
      for (int i = 0; i < NUM_MSG; i++) begin
         if (bus.sel == SEL_W'(i)) x_sel = bus.rand_msgs[i*WIDTH +: WIDTH];
      end
      req_err = ({1'b0, bus.sel} >= (SEL_W+1)'(NUM_MSG)) || (bus.N < WIDTH'(2));
`ifdef OT_RECEIVER_RANGE_CHECK_EN
      req_err = req_err || (bus.rand_val >= bus.N) || (x_sel >= bus.N);
`else
      req_err = req_err || 1'b0;
`endif
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state logic; engine done is only honoured in EXP and RED.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (bus.start) state_d = req_err ? OUT : EXP;
         EXP:     if (eng_end) state_d = RED;
         RED:     if (eng_end) state_d = ADD;
         ADD:     state_d = OUT;
         OUT:     if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Datapath updates: operand capture, partial results, modular add.
   always_comb begin
      n_d        = n_q;
      e_d        = e_q;
      k_d        = k_q;
      x_d        = x_q;
      a_d        = a_q;
      b_d        = b_q;
      v_d        = v_q;
      err_d      = err_q;
      md_start_d = 1'b0;
      sum        = {1'b0, a_q} + {1'b0, b_q};
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               n_d = bus.N;
               e_d = bus.pub_key;
               k_d = bus.rand_val;
               x_d = x_sel;
               if (req_err) begin
                  err_d = 1'b1;
                  v_d   = '0;
               end else begin
                  err_d      = 1'b0;
                  md_start_d = 1'b1;
               end
            end
         end
         EXP: begin
            if (eng_end) begin
               a_d        = eng_r;
               md_start_d = 1'b1;
            end
         end
         RED: begin
            if (eng_end) b_d = eng_r;
         end
         ADD: begin
            v_d = (sum >= {1'b0, n_q}) ? WIDTH'(sum - {1'b0, n_q}) : WIDTH'(sum);
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_q        <= '0;
         e_q        <= '0;
         k_q        <= '0;
         x_q        <= '0;
         a_q        <= '0;
         b_q        <= '0;
         v_q        <= '0;
         err_q      <= 1'b0;
         md_start_q <= 1'b0;
      end else begin
         n_q        <= n_d;
         e_q        <= e_d;
         k_q        <= k_d;
         x_q        <= x_d;
         a_q        <= a_d;
         b_q        <= b_d;
         v_q        <= v_d;
         err_q      <= err_d;
         md_start_q <= md_start_d;
      end
   end

   // Engine operands follow the state the start pulse is issued in.
   assign eng_base = (state_q == RED) ? x_q : k_q;
   assign eng_exp  = (state_q == RED) ? WIDTH'(1) : e_q;

   rl_modexp #(.WIDTH(WIDTH)) u_modexp (
      .clk      (clk),
      .rst      (rst),
      .md_start (md_start_q),
      .base     (eng_base),
      .exp      (eng_exp),
      .modulus  (n_q),
      .r        (eng_r),
      .md_end   (eng_end)
   );

   // Handshake outputs.
   always_comb begin
      bus.in_ready  = (state_q == IDLE);
      bus.out_valid = (state_q == OUT);
      bus.v         = v_q;
      bus.err       = err_q;
   end

endmodule

// File: tb/tb_ot_receiver_rsa.sv
module tb_ot_receiver_rsa;

`ifdef OT_RECEIVER_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif
   localparam int TMO = 5000;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   md3_seen = 1'b0;

   always #5 clk = ~clk;

   ot_receiver_rsa_if #(.WIDTH(32), .NUM_MSG(2)) if2 ();
   ot_receiver_rsa_if #(.WIDTH(32), .NUM_MSG(3)) if3 ();
   ot_receiver_rsa_if #(.WIDTH(32), .NUM_MSG(4)) if4 ();

   ot_receiver_rsa #(.WIDTH(32), .NUM_MSG(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
   ot_receiver_rsa #(.WIDTH(32), .NUM_MSG(3)) dut3 (.clk(clk), .rst(rst), .bus(if3));
   ot_receiver_rsa #(.WIDTH(32), .NUM_MSG(4)) dut4 (.clk(clk), .rst(rst), .bus(if4));

   always @(posedge clk) if (dut3.md_start_q) md3_seen = 1'b1;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic fail(input string tag, input longint obs, input longint expv);
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
   endtask

   task automatic req2(input logic s, input logic [31:0] k, input logic [31:0] e,
                       input logic [31:0] n, input logic [31:0] ev, input logic eerr,
                       input string tag, output int cyc);
      @(negedge clk);
      if2.sel = s; if2.rand_val = k; if2.pub_key = e; if2.N = n; if2.start = 1'b1;
      @(negedge clk);
      if2.start = 1'b0;
      cyc = 0;
      while (!if2.out_valid && cyc < TMO) begin @(negedge clk); cyc++; end
      n_chk++; if (if2.out_valid !== 1'b1) fail({tag, " valid"}, if2.out_valid, 1);
      n_chk++; if (if2.v !== ev) fail({tag, " v"}, if2.v, ev);
      n_chk++; if (if2.err !== eerr) fail({tag, " err"}, if2.err, eerr);
      if2.out_ready = 1'b1;
      @(negedge clk);
      if2.out_ready = 1'b0;
      n_chk++; if (if2.in_ready !== 1'b1) fail({tag, " in_ready after ack"}, if2.in_ready, 1);
      n_chk++; if (if2.out_valid !== 1'b0) fail({tag, " out_valid after ack"}, if2.out_valid, 0);
   endtask

   initial begin
      int cyc;
      if2.start = 0; if2.sel = '0; if2.N = 0; if2.pub_key = 0; if2.rand_val = 0; if2.out_ready = 0;
      if2.rand_msgs = {32'd3000, 32'd100};
      if3.start = 0; if3.sel = '0; if3.N = 0; if3.pub_key = 0; if3.rand_val = 0; if3.out_ready = 0;
      if3.rand_msgs = {32'd7, 32'd3000, 32'd100};
      if4.start = 0; if4.sel = '0; if4.N = 0; if4.pub_key = 0; if4.rand_val = 0; if4.out_ready = 0;
      if4.rand_msgs = {32'd5000, 32'd9, 32'd3000, 32'd100};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_chk++; if (if2.in_ready !== 1'b1) fail("reset in_ready", if2.in_ready, 1);
      n_chk++; if (if2.out_valid !== 1'b0) fail("reset out_valid", if2.out_valid, 0);
      n_chk++; if (if2.v !== 32'd0) fail("reset v", if2.v, 0);
      n_chk++; if (if2.err !== 1'b0) fail("reset err", if2.err, 0);

      req2(1'b1, 32'd65, 32'd17, 32'd3233, 32'd2557, 1'b0, "sel1", cyc);
      req2(1'b0, 32'd65, 32'd17, 32'd3233, 32'd2890, 1'b0, "sel0", cyc);
      req2(1'b1, 32'd65, 32'd0, 32'd3233, 32'd3001, 1'b0, "e0", cyc);
      req2(1'b1, 32'd4000, 32'd17, 32'd3233, RC ? 32'd0 : 32'd17, RC, "k>=N", cyc);
      req2(1'b1, 32'd65, 32'd17, 32'd2, RC ? 32'd0 : 32'd1, RC, "N=2", cyc);
      req2(1'b0, 32'd65, 32'd17, 32'd1, 32'd0, 1'b1, "N=1", cyc);
      n_chk++; if (cyc !== 0) fail("N=1 latency", cyc, 0);

      @(negedge clk);
      if2.sel = 1'b1; if2.rand_val = 32'd65; if2.pub_key = 32'd17; if2.N = 32'd3233; if2.start = 1'b1;
      @(negedge clk);
      if2.start = 1'b0;
      cyc = 0;
      while (!if2.out_valid && cyc < TMO) begin @(negedge clk); cyc++; end
      n_chk++; if (if2.out_valid !== 1'b1) fail("stall first valid", if2.out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         if2.start = 1'b1; if2.sel = 1'b0; if2.rand_val = 32'(i + 3);
         @(negedge clk);
         n_chk++; if (if2.out_valid !== 1'b1) fail("stall valid", if2.out_valid, 1);
         n_chk++; if (if2.v !== 32'd2557) fail("stall v", if2.v, 2557);
         n_chk++; if (if2.err !== 1'b0) fail("stall err", if2.err, 0);
         n_chk++; if (if2.in_ready !== 1'b0) fail("stall in_ready", if2.in_ready, 0);
      end
      if2.start = 1'b0; if2.out_ready = 1'b1;
      @(negedge clk);
      if2.out_ready = 1'b0;
      n_chk++; if (if2.in_ready !== 1'b1) fail("stall release in_ready", if2.in_ready, 1);
      n_chk++; if (if2.out_valid !== 1'b0) fail("stall release out_valid", if2.out_valid, 0);

      if2.sel = 1'b1; if2.rand_val = 32'd65; if2.pub_key = 32'd17; if2.N = 32'd3233; if2.start = 1'b1;
      @(negedge clk);
      if2.start = 1'b0;
      repeat (20) @(negedge clk);
      n_chk++; if (if2.in_ready !== 1'b0) fail("mid-EXP busy", if2.in_ready, 0);
      rst = 1'b1;
      @(negedge clk);
      n_chk++; if (if2.out_valid !== 1'b0) fail("rst out_valid", if2.out_valid, 0);
      n_chk++; if (if2.in_ready !== 1'b1) fail("rst in_ready", if2.in_ready, 1);
      rst = 1'b0;
      req2(1'b1, 32'd65, 32'd17, 32'd3233, 32'd2557, 1'b0, "after rst", cyc);

      @(negedge clk);
      if4.sel = 2'd3; if4.rand_val = 32'd65; if4.pub_key = 32'd17; if4.N = 32'd3233; if4.start = 1'b1;
      @(negedge clk);
      if4.start = 1'b0;
      cyc = 0;
      while (!if4.out_valid && cyc < TMO) begin @(negedge clk); cyc++; end
      n_chk++; if (if4.out_valid !== 1'b1) fail("n4 valid", if4.out_valid, 1);
      n_chk++; if (if4.v !== (RC ? 32'd0 : 32'd1324)) fail("n4 v", if4.v, RC ? 0 : 1324);
      n_chk++; if (if4.err !== RC) fail("n4 err", if4.err, RC);
      if4.out_ready = 1'b1;
      @(negedge clk);
      if4.out_ready = 1'b0;

      md3_seen = 1'b0;
      if3.sel = 2'd3; if3.rand_val = 32'd65; if3.pub_key = 32'd17; if3.N = 32'd3233; if3.start = 1'b1;
      @(negedge clk);
      if3.start = 1'b0;
      n_chk++; if (if3.out_valid !== 1'b1) fail("n3 valid next cycle", if3.out_valid, 1);
      n_chk++; if (if3.err !== 1'b1) fail("n3 err", if3.err, 1);
      n_chk++; if (if3.v !== 32'd0) fail("n3 v", if3.v, 0);
      if3.out_ready = 1'b1;
      @(negedge clk);
      if3.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++; if (if3.in_ready !== 1'b1) fail("n3 in_ready", if3.in_ready, 1);
      n_chk++; if (md3_seen !== 1'b0) fail("n3 engine start", md3_seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
